// File: rtl/data_ram_ctrl_pkg.sv
// ============================================================================
// Module      : data_ram_ctrl_pkg
// Description : Shared constants, state encoding and address-range helper
//               for the data-side RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_ram_ctrl_pkg;

  // Bus-level constants shared with the MEM stage
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   REG_BUS      = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  // Wait-state counter width (WAIT_CYCLES is limited to 0..7)
  localparam int CNT_W = 3;

  // Access FSM encoding
  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_BUSY = 2'd1,
    DRAM_DONE = 2'd2
  } dram_state_e;

  // True when every address bit above the word index is zero
  function automatic logic addr_in_range(input logic [REG_BUS-1:0] addr,
                                         input int unsigned        depth_log2);
    logic [REG_BUS-1:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (hi == ZERO_WORD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_ctrl_byte_bank.sv
// ============================================================================
// Module      : dram_byte_bank
// Description : One byte lane of the data RAM: 8-bit x 2^ADDR_W array with
//               write enable and an enabled, unreset read register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_byte_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Array write and read-register capture; neither is reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_ram_ctrl.sv
// ============================================================================
// Module      : data_ram_ctrl
// Description : MEM-stage data RAM responder. Each access spends WAIT_CYCLES
//               extra busy cycles, holds the pipeline via stallreq_o, and
//               completes through a one-cycle DONE state. Four byte banks
//               form a big-endian word (sel[3] = bits 31:24).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,       // active-high asynchronous reset
  input  logic               mem_ce_i,
  input  logic               mem_we_i,
  input  logic [REG_BUS-1:0] mem_addr_i,
  input  logic [3:0]         mem_sel_i,
  input  logic [REG_BUS-1:0] mem_data_i,
  output logic [REG_BUS-1:0] mem_data_o,
  output logic               stallreq_o,
  output logic               addr_err_o
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  dram_state_e        state;
  dram_state_e        state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  in_range;
  logic                  access;
  logic                  rd_en;
  logic [3:0]            lane_we;
  logic [REG_BUS-1:0]    bank_rdata;
  logic                  rd_zero;   // last completed read was out of range (or none since reset)
  logic                  err_q;
  logic                  unused_addr_lsb;

  // Byte offset is the MEM stage's concern; only word-aligned index is used
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  assign word_idx = mem_addr_i[DEPTH_LOG2+1:2];
  assign in_range = addr_in_range(mem_addr_i, DEPTH_LOG2);

  // The access edge: last BUSY cycle with the request still present
  assign access = (state == DRAM_BUSY) && (mem_ce_i == CHIP_ENABLE) && (cnt == '0);
  assign rd_en  = access && (mem_we_i != WRITE_ENABLE) && in_range;

  // State and wait counter registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= DRAM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      DRAM_IDLE: begin
        if (mem_ce_i == CHIP_ENABLE) begin
          state_next = DRAM_BUSY;
          cnt_next   = WAIT_LOAD;
        end
      end
      DRAM_BUSY: begin
        if (mem_ce_i != CHIP_ENABLE) begin
          // Flush or exception withdrew the request: abandon without side effects
          state_next = DRAM_IDLE;
        end else if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = DRAM_DONE;
        end
      end
      DRAM_DONE: begin
        state_next = DRAM_IDLE;
      end
      default: begin
        state_next = DRAM_IDLE;
      end
    endcase
  end

  // Remember range status of the completed access for the DONE cycle and read path
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_q   <= 1'b0;
      rd_zero <= 1'b1;
    end else if (access) begin
      err_q <= ~in_range;
      if (mem_we_i != WRITE_ENABLE) begin
        rd_zero <= ~in_range;
      end
    end
  end

  // One bank per byte lane; lane i carries bits 8i+7:8i
  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign lane_we[i] = access && (mem_we_i == WRITE_ENABLE) && in_range && mem_sel_i[i];

      dram_byte_bank #(
        .ADDR_W (DEPTH_LOG2)
      ) u_bank (
        .clk   (clk),
        .we    (lane_we[i]),
        .re    (rd_en),
        .addr  (word_idx),
        .wdata (mem_data_i[8*i +: 8]),
        .rdata (bank_rdata[8*i +: 8])
      );
    end
  endgenerate

  // Bank read registers are unreset, so a zero flag supplies the reset and
  // out-of-range read value without a second data register
  assign mem_data_o = rd_zero ? ZERO_WORD : bank_rdata;
  assign stallreq_o = mem_ce_i & (state != DRAM_DONE);
  assign addr_err_o = (state == DRAM_DONE) & err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
// ============================================================================
// Module      : tb_data_ram_ctrl
// Description : Directed, self-checking bench for data_ram_ctrl using three
//               instances (WAIT_CYCLES = 0, 1, 7) and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ce  = '0;
  logic        we  = 1'b0;
  logic [31:0] addr  = '0;
  logic [3:0]  sel   = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rd    [3];
  logic        stall [3];
  logic        err   [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst), .mem_ce_i(ce[0]), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd[0]), .stallreq_o(stall[0]),
    .addr_err_o(err[0]));

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst), .mem_ce_i(ce[1]), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd[1]), .stallreq_o(stall[1]),
    .addr_err_o(err[1]));

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(7)) u_w7 (
    .clk(clk), .rst_n(rst), .mem_ce_i(ce[2]), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd[2]), .stallreq_o(stall[2]),
    .addr_err_o(err[2]));

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access on instance k, started #1 after a rising edge
  task automatic do_access(input int k, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d, input string tag);
    int          key;
    logic        ok;
    int          n;
    logic        done;
    logic        err_busy;
    logic [31:0] cur;
    ok  = (a[31:12] == 20'h0);
    key = k * 4096 + int'(a[11:2]);
    cur = 32'h0;
    if (w) begin
      if (ok) begin
        cur = model.exists(key) ? model[key] : 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        end
        model[key] = cur;
      end
    end else begin
      exp_q.push_back(ok ? model[key] : 32'h0);
    end

    we = w; addr = a; sel = s; wdata = d; ce[k] = 1'b1;
    n = 0; done = 1'b0; err_busy = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall[k]) begin
        n++;
        err_busy = err_busy | err[k];
      end else begin
        done = 1'b1;
      end
    end
    check({tag, " done"},     32'(done),     32'd1);
    check({tag, " stall"},    32'(n),        32'(wait_of(k) + 2));
    check({tag, " err_busy"}, 32'(err_busy), 32'd0);
    check({tag, " err_done"}, 32'(err[k]),   32'(!ok));
    if (!w) begin
      cur = exp_q.pop_front();
      check({tag, " rdata"}, rd[k], cur);
    end
    @(posedge clk);
    #1;
    ce[k] = 1'b0;
    we    = 1'b0;
    check({tag, " err_after"}, 32'(err[k]), 32'd0);
    if (!w) check({tag, " hold"}, rd[k], cur);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset rdata%0d", k), rd[k], 32'h0);
      check($sformatf("reset stall%0d", k), 32'(stall[k]), 32'd0);
      check($sformatf("reset err%0d", k),   32'(err[k]),   32'd0);
    end
    @(posedge clk);
    #1;

    // Word and byte writes, zero-select write, reads back
    do_access(1, 1'b1, 32'h10, 4'hF,    32'h12345678, "sw10");
    do_access(1, 1'b0, 32'h10, 4'hF,    32'h0,        "lw10a");
    do_access(1, 1'b1, 32'h10, 4'b0100, 32'hABABABAB, "sb10");
    do_access(1, 1'b0, 32'h10, 4'hF,    32'h0,        "lw10b");
    check("sb merge model", model[1*4096 + 4], 32'h12AB5678);
    do_access(1, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, "sel0");
    do_access(1, 1'b0, 32'h10, 4'hF,    32'h0,        "lw10c");

    // Out-of-range: write dropped (would alias word 0), read returns zero
    do_access(1, 1'b1, 32'h0,    4'hF, 32'h0BADF00D, "sw00");
    do_access(1, 1'b1, 32'h1000, 4'hF, 32'h55555555, "sw_oor");
    do_access(1, 1'b0, 32'h1000, 4'hF, 32'h0,        "lw_oor");
    do_access(1, 1'b0, 32'h0,    4'hF, 32'h0,        "lw00");

    // Request withdrawn during BUSY: no write, read data untouched
    we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'hDEADBEEF; ce[1] = 1'b1;
    @(posedge clk);
    #1;
    ce[1] = 1'b0;
    #1;
    check("abort stall", 32'(stall[1]), 32'd0);
    @(posedge clk);
    #1;
    check("abort hold", rd[1], 32'h0BADF00D);
    we = 1'b0;
    @(posedge clk);
    #1;
    do_access(1, 1'b0, 32'h10, 4'hF, 32'h0, "lw_abort");

    // Reset during BUSY: write lost, read register cleared
    we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'hDEADBEEF; ce[1] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst rdata", rd[1], 32'h0);
    check("rst stall ce1", 32'(stall[1]), 32'd1);
    ce[1] = 1'b0;
    we    = 1'b0;
    #1;
    check("rst stall ce0", 32'(stall[1]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_access(1, 1'b0, 32'h10, 4'hF, 32'h0, "lw_rst");

    // Wait-state extremes
    do_access(0, 1'b1, 32'h20, 4'hF, 32'hCAFE0001, "w0_sw");
    do_access(0, 1'b0, 32'h20, 4'hF, 32'h0,        "w0_lw");
    do_access(2, 1'b1, 32'h24, 4'hF, 32'h0F1E2D3C, "w7_sw");
    do_access(2, 1'b0, 32'h24, 4'hF, 32'h0,        "w7_lw");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
